// File: rtl/if_prefetch.sv
// Instruction fetch with a decoupled prefetch FIFO. Requests stay in flight across
// redirects, and their stale responses are dropped through a discard counter.
module if_prefetch #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter int unsigned     MAX_OUT  = 2,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  input  logic            StallD,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     InstrnD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCplus4D,
  output logic            ValidD
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1) + 1;

  logic [XLEN-1:0] pcf;
  logic [XLEN-1:0] resp_pc;
  logic [XLEN-1:0] redir_pc;
  logic [31:0]     fifo_instr [DEPTH];
  logic [XLEN-1:0] fifo_pc    [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   fifo_count;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   out_next;
  logic [CW-1:0]   discard;
  logic            grant;
  logic            push;
  logic            pop;

  assign redir_pc  = PCTargetE & ~XLEN'(3);
  assign imem_addr = pcf;
  // Uses only registered state, so redirects and stalls take effect one cycle later.
  assign imem_req  = !rst && (outstanding < CW'(MAX_OUT))
                     && ((fifo_count + outstanding) < CW'(DEPTH));
  assign grant     = imem_req && imem_gnt;
  assign push      = imem_rvalid && !PCSrcE && (discard == '0);
  assign pop       = !PCSrcE && !StallD && (fifo_count != '0);

  always_comb begin
    out_next = outstanding;
    if (grant && !imem_rvalid)
      out_next = outstanding + CW'(1);
    else if (imem_rvalid && !grant)
      out_next = outstanding - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcf     <= RESET_PC;
      resp_pc <= RESET_PC;
    end else if (PCSrcE) begin
      pcf     <= redir_pc;
      resp_pc <= redir_pc;
    end else begin
      if (grant) pcf     <= pcf + XLEN'(4);
      if (push)  resp_pc <= resp_pc + XLEN'(4);
    end
  end

  // Everything still in flight at a redirect belongs to the old path,
  // including a request granted on the redirect edge itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= out_next;
      if (PCSrcE)
        discard <= out_next;
      else if (imem_rvalid && (discard != '0))
        discard <= discard - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_instr[i] <= '0;
        fifo_pc[i]    <= '0;
      end
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (PCSrcE) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        fifo_instr[wr_ptr] <= imem_rdata;
        fifo_pc[wr_ptr]    <= resp_pc;
        wr_ptr             <= wr_ptr + AW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)
        fifo_count <= fifo_count + CW'(1);
      else if (pop && !push)
        fifo_count <= fifo_count - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      InstrnD  <= '0;
      PCD      <= '0;
      PCplus4D <= '0;
      ValidD   <= 1'b0;
    end else if (PCSrcE) begin
      ValidD <= 1'b0;
    end else if (!StallD) begin
      if (fifo_count != '0) begin
        InstrnD  <= fifo_instr[rd_ptr];
        PCD      <= fifo_pc[rd_ptr];
        PCplus4D <= fifo_pc[rd_ptr] + XLEN'(4);
        ValidD   <= 1'b1;
      end else begin
        ValidD <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_if_prefetch.sv
// Bench for if_prefetch: an in-order memory responder with random latency, checked
// against a queue model of in-flight requests and fetched words.
module tb_if_prefetch;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned MAX_OUT = 2;
  localparam logic [31:0] RPC     = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        PCSrcE = 1'b0;
  logic [31:0] PCTargetE = '0;
  logic        StallD = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] InstrnD;
  logic [31:0] PCD;
  logic [31:0] PCplus4D;
  logic        ValidD;

  always #5 clk = ~clk;

  if_prefetch #(
    .XLEN(XLEN), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(RPC)
  ) dut (
    .clk(clk), .rst(rst), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .StallD(StallD),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .InstrnD(InstrnD), .PCD(PCD), .PCplus4D(PCplus4D), .ValidD(ValidD)
  );

  typedef struct {
    logic [31:0] addr;
    int unsigned ready;
    bit          stale;
  } req_t;

  req_t        reqq[$];
  logic [31:0] fq[$];
  logic [31:0] mpcf;
  logic        ev;
  logic [31:0] epc, ein, ep4;
  int unsigned cyc = 0;
  int unsigned delivered = 0;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    reqq.delete();
    fq.delete();
    mpcf = RPC;
    ev   = 1'b0;
    epc  = '0;
    ein  = '0;
    ep4  = '0;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    PCSrcE      = 1'b0;
    StallD      = 1'b0;
    #1;
    chk("rst_valid", ValidD, 1'b0);
    chk("rst_req", imem_req, 1'b0);
    chk("rst_pcd", PCD, 32'h0);
    chk("rst_instr", InstrnD, 32'h0);
    chk("rst_pc4", PCplus4D, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    chk("post_rst_req", imem_req, 1'b1);
    chk("post_rst_addr", imem_addr, RPC);
  endtask

  // One clock: drive inputs, check the request side, clock, then check IF/ID.
  task automatic step(input bit g, input bit rvreq, input bit redir,
                      input logic [31:0] tgt, input bit stall, input int unsigned lat);
    bit          req_e, grant, rv;
    int unsigned fb;
    req_t        h;
    rv          = rvreq && (reqq.size() > 0) && (reqq[0].ready <= cyc);
    imem_gnt    = g;
    PCSrcE      = redir;
    PCTargetE   = tgt;
    StallD      = stall;
    imem_rvalid = rv;
    imem_rdata  = rv ? word_of(reqq[0].addr) : $urandom;
    #1;
    req_e = (reqq.size() < MAX_OUT) && ((fq.size() + reqq.size()) < DEPTH);
    chk("imem_req", imem_req, req_e);
    if (req_e) chk("imem_addr", imem_addr, mpcf);
    grant = req_e && g;
    @(posedge clk);
    #1;
    cyc++;
    fb = fq.size();
    if (rv) begin
      h = reqq.pop_front();
      if (!redir && !h.stale) fq.push_back(h.addr);
    end
    if (grant) begin
      h.addr  = mpcf;
      h.ready = cyc + lat;
      h.stale = 1'b0;
      reqq.push_back(h);
      mpcf = mpcf + 32'd4;
    end
    if (redir) begin
      foreach (reqq[i]) reqq[i].stale = 1'b1;
      fq.delete();
      mpcf = tgt & ~32'h3;
      ev   = 1'b0;
    end else if (!stall) begin
      if (fb > 0) begin
        epc = fq.pop_front();
        ein = word_of(epc);
        ep4 = epc + 32'd4;
        ev  = 1'b1;
        delivered++;
      end else begin
        ev = 1'b0;
      end
    end
    chk("ValidD", ValidD, ev);
    chk("PCD", PCD, epc);
    chk("InstrnD", InstrnD, ein);
    chk("PCplus4D", PCplus4D, ep4);
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // streaming from RESET_PC across the address wrap
    for (int i = 1; i <= 12; i++) begin
      step(1, 1, 0, '0, 0, 0);
      if (i >= 4) chk("valid_by4", ValidD, 1'b1);
    end

    // long decode stall saturates the prefetch window
    for (int i = 0; i < 10; i++) step(1, 1, 0, '0, 1, 0);
    chk("stall_req_low", imem_req, 1'b0);
    for (int i = 0; i < 8; i++) step(1, 1, 0, '0, 0, 0);

    // redirect with two requests outstanding, misaligned target
    for (int i = 0; i < 3; i++) step(1, 0, 0, '0, 0, 0);
    chk("two_out_req_low", imem_req, 1'b0);
    step(1, 0, 1, 32'h0000_0103, 0, 0);
    for (int k = 0; k < 20 && !ValidD; k++) step(1, 1, 0, '0, 0, 0);
    chk("redir_valid_seen", ValidD, 1'b1);
    chk("redir_pcd", PCD, 32'h0000_0100);
    chk("redir_pc4", PCplus4D, 32'h0000_0104);

    // redirect coinciding with a grant and a response
    for (int i = 0; i < 4; i++) step(1, 1, 0, '0, 0, 0);
    chk("pre_redir_req", imem_req, 1'b1);
    step(1, 1, 1, 32'h0000_2000, 0, 0);
    for (int k = 0; k < 20 && !ValidD; k++) step(1, 1, 0, '0, 0, 0);
    chk("redir2_pcd", PCD, 32'h0000_2000);

    // back-to-back redirects while stale responses are pending
    for (int i = 0; i < 2; i++) step(1, 0, 0, '0, 0, 0);
    step(1, 1, 1, 32'h0000_3000, 0, 0);
    step(1, 1, 1, 32'h0000_4004, 0, 1);
    for (int k = 0; k < 20 && !ValidD; k++) step(1, 1, 0, '0, 0, 1);
    chk("redir3_pcd", PCD, 32'h0000_4004);

    // mid-stream reset
    for (int i = 0; i < 3; i++) step(1, 1, 0, '0, 0, 0);
    #2;
    do_reset();

    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tgt;
      tgt = $urandom;
      if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      if ($urandom_range(0, 299) == 0) begin
        #2;
        do_reset();
      end else begin
        step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
             $urandom_range(0, 19) == 0, tgt, $urandom_range(0, 3) == 0,
             $urandom_range(0, 3));
      end
    end
    chk("progress", delivered > 500, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_prefetch.md
IF_PREFETCH -- requirements
Module: if_prefetch

Interface
REQ-001 Parameter XLEN, default 32, width of all PC and address values.
REQ-002 Parameter DEPTH, default 4, prefetch FIFO entries; power of two, >=2.
REQ-003 Parameter MAX_OUT, default 2, maximum imem requests in flight, 1..DEPTH.
REQ-004 Parameter RESET_PC, default 0, first fetch address after reset.
REQ-005 One clock and one reset: the reset is asynchronous and active-high.
REQ-006 clk  in  1  sole clock; all state changes on rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 PCSrcE  in  1  redirect request from execute.
REQ-009 PCTargetE  in  XLEN  redirect target address.
REQ-010 StallD  in  1  decode stall; holds IF/ID outputs.
REQ-011 imem_req  out  1  fetch request valid.
REQ-012 imem_addr  out  XLEN  fetch address, equal to the fetch PC (pcf).
REQ-013 imem_gnt  in  1  request accepted when imem_req and imem_gnt are both high.
REQ-014 imem_rvalid  in  1  in-order response valid, earliest one cycle after grant.
REQ-015 imem_rdata  in  32  response instruction word.
REQ-016 InstrnD, PCD, PCplus4D  out  32/XLEN/XLEN  registered IF/ID instruction, PC and PC+4.
REQ-017 ValidD  out  1  IF/ID register holds a real instruction.

Function
REQ-018 pcf shall advance by 4 (mod 2^XLEN) on each grant, so 0xFFFFFFFC wraps to 0.
REQ-019 imem_req shall be high iff rst low, outstanding<MAX_OUT, and fifo_count+outstanding<DEPTH; it shall not depend combinationally on PCSrcE or StallD.
REQ-020 outstanding shall increment on grant, decrement on imem_rvalid, and stay unchanged when both occur.
REQ-021 A response with discard=0 shall be pushed into the FIFO as {imem_rdata, resp_pc}; resp_pc then advances by 4.
REQ-022 A response with discard>0 shall be dropped and shall decrement discard.
REQ-023 With StallD low, a non-empty FIFO shall pop its head into InstrnD/PCD/PCplus4D=PCD+4 and set ValidD=1; an empty FIFO shall set ValidD=0 and hold the data outputs.
REQ-024 With StallD high, all IF/ID outputs shall hold; a full FIFO shall then back-pressure through REQ-019.
REQ-025 No FIFO bypass: a word pushed at edge N shall appear on InstrnD no earlier than edge N+1.
REQ-026 PCSrcE=1 shall, at that edge, load pcf and resp_pc with {PCTargetE[XLEN-1:2],2'b00}, empty the FIFO, clear ValidD, and ignore StallD.
REQ-027 On redirect, discard shall load outstanding + (grant this cycle) - (rvalid this cycle); the rvalid arriving in the redirect cycle shall be dropped.
REQ-028 Further PCSrcE pulses while discard>0 shall recompute discard by REQ-027; no old-path word shall ever reach InstrnD.
REQ-029 Simultaneous push and pop shall leave fifo_count unchanged; push to a full FIFO is impossible by REQ-019.

Reset
REQ-030 rst high shall immediately clear InstrnD, PCD, PCplus4D, ValidD, FIFO, outstanding and discard, and drive imem_req=0.
REQ-031 rst high shall immediately set pcf and resp_pc to RESET_PC.
REQ-032 Reset asserted mid-transaction shall abandon in-flight requests; responses arriving after release without a matching post-reset grant are a protocol violation and are not checked.
REQ-033 The first imem_req shall rise in the first cycle after rst deasserts, with imem_addr=RESET_PC.

Verification
REQ-034 Reset, gnt=1 always, rvalid 1 cycle after grant, StallD=0 -> imem_addr 0,4,8,...; InstrnD streams words in order; ValidD goes high by cycle 4 and stays high.
REQ-035 StallD held high 10 cycles -> outputs frozen; imem_req drops once fifo_count+outstanding=4; on release the words come out in order with no loss or duplication.
REQ-036 Redirect to 0x100 with 2 requests outstanding -> both old responses dropped (discard 2->0); next ValidD=1 shows PCD=0x100, PCplus4D=0x104.
REQ-037 Redirect in the same cycle as a grant and an rvalid -> discard computed per REQ-027; no old-path PCD is ever observed.
REQ-038 RESET_PC=0xFFFFFFF8 -> PCD sequence FFFFFFF8, FFFFFFFC, 00000000; PCTargetE=0x103 -> fetch address 0x100.
REQ-039 rst asserted mid-stream -> ValidD=0, imem_req=0 in the same cycle; after release imem_addr=RESET_PC.
